// File: rtl/gamepad_button_encoder_if.sv
// Press handshake bundle between the button debouncers (master) and
// gamepad_button_encoder (slave).
interface gamepad_button_encoder_if #(
    parameter int unsigned NUM_BUTTONS = 8
);
    logic [NUM_BUTTONS-1:0] press_activated;
    logic [NUM_BUTTONS-1:0] press_accepted;

    modport master (
        output press_activated,
        input  press_accepted
    );

    modport slave (
        input  press_activated,
        output press_accepted
    );
endinterface

// File: rtl/gamepad_button_encoder.sv
// Holds accepted button presses for HOLD_FRAMES latch frames and serialises them as an
// active-low Famicom-style pad stream. Define GAMEPAD_STROBE_SYNC_EN to synchronise the strobes.
module gamepad_button_encoder #(
    parameter int unsigned NUM_BUTTONS = 8,
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    gamepad_button_encoder_if.slave        btn_if,
    input  logic                           pad_latch,
    input  logic                           pad_shift,
    output logic                           pad_data,
    output logic [NUM_BUTTONS-1:0]         buttons_held
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_HOLD = 2'b10
    } chan_state_e;

    localparam logic [3:0] HOLD_LOAD = (HOLD_FRAMES == 0) ? 4'd1 : 4'(HOLD_FRAMES);

    chan_state_e            state_q [NUM_BUTTONS];
    chan_state_e            state_d [NUM_BUTTONS];
    logic [3:0]             cnt_q   [NUM_BUTTONS];
    logic [3:0]             cnt_d   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] accepted_q;
    logic [NUM_BUTTONS-1:0] accepted_d;
    logic [NUM_BUTTONS-1:0] held;
    logic [7:0]             held8;
    logic [7:0]             shreg_q;
    logic [7:0]             shreg_d;
    logic                   latch_prev_q;
    logic                   latch_prev_d;
    logic                   shift_prev_q;
    logic                   shift_prev_d;
    logic                   latch_s;
    logic                   shift_s;
    logic                   latch_evt;
    logic                   shift_evt;

`ifdef GAMEPAD_STROBE_SYNC_EN
    logic [1:0] latch_sync_q;
    logic [1:0] latch_sync_d;
    logic [1:0] shift_sync_q;
    logic [1:0] shift_sync_d;

    always_comb begin
        latch_sync_d = {latch_sync_q[0], pad_latch};
        shift_sync_d = {shift_sync_q[0], pad_shift};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            latch_sync_q <= '0;
            shift_sync_q <= '0;
        end else begin
            latch_sync_q <= latch_sync_d;
            shift_sync_q <= shift_sync_d;
        end
    end

    assign latch_s = latch_sync_q[1];
    assign shift_s = shift_sync_q[1];
`else
    assign latch_s = pad_latch;
    assign shift_s = pad_shift;
`endif

    always_comb begin
        latch_prev_d = latch_s;
        shift_prev_d = shift_s;
        latch_evt    = latch_s & ~latch_prev_q;
        shift_evt    = shift_s & ~shift_prev_q;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            held[i] = (state_q[i] == ST_HOLD);
        end
    end

    // Per-channel FSM; held[] is the pre-update view, so a latch in the ACK->HOLD cycle loads 0.
    always_comb begin
        accepted_d = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (btn_if.press_activated[i]) begin
                        accepted_d[i] = 1'b1;
                        state_d[i]    = ST_ACK;
                    end
                end
                ST_ACK: begin
                    cnt_d[i]   = HOLD_LOAD;
                    state_d[i] = ST_HOLD;
                end
                ST_HOLD: begin
                    if (latch_evt) begin
                        if (cnt_q[i] <= 4'd1) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Channel i maps to shift bit 7-i; positions without a channel read as released.
    always_comb begin
        held8                  = '0;
        held8[NUM_BUTTONS-1:0] = held;
        shreg_d                = shreg_q;
        if (latch_evt) begin
            for (int unsigned i = 0; i < 8; i++) begin
                shreg_d[7-i] = ~held8[i];
            end
        end else if (shift_evt) begin
            shreg_d = {shreg_q[6:0], 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            accepted_q   <= '0;
            shreg_q      <= '1;
            latch_prev_q <= 1'b0;
            shift_prev_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            accepted_q   <= accepted_d;
            shreg_q      <= shreg_d;
            latch_prev_q <= latch_prev_d;
            shift_prev_q <= shift_prev_d;
        end
    end

    assign btn_if.press_accepted = accepted_q;
    assign buttons_held          = held;
    assign pad_data              = shreg_q[7];

endmodule

// File: tb/tb_gamepad_button_encoder.sv
// Directed-vector bench for gamepad_button_encoder (8 buttons, 2 hold frames).
module tb_gamepad_button_encoder;
`ifdef GAMEPAD_STROBE_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pad_latch;
    logic       pad_shift;
    logic       pad_data;
    logic [7:0] buttons_held;

    int unsigned n_vec   = 0;
    int unsigned n_err   = 0;
    int unsigned ack0_cnt = 0;

    gamepad_button_encoder_if #(.NUM_BUTTONS(8)) btn_if ();

    gamepad_button_encoder #(
        .NUM_BUTTONS(8),
        .HOLD_FRAMES(2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_if       (btn_if.slave),
        .pad_latch    (pad_latch),
        .pad_shift    (pad_shift),
        .pad_data     (pad_data),
        .buttons_held (buttons_held)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (btn_if.press_accepted[0] === 1'b1) ack0_cnt++;
        end
    endtask

    task automatic pulse_latch();
        pad_latch = 1'b1;
        tick(1);
        pad_latch = 1'b0;
        tick(1 + SYNC_LAT);
    endtask

    task automatic pulse_shift();
        pad_shift = 1'b1;
        tick(1);
        pad_shift = 1'b0;
        tick(1 + SYNC_LAT);
    endtask

    task automatic read_bits(output logic [7:0] v);
        v[7] = pad_data;
        for (int k = 6; k >= 0; k--) begin
            pulse_shift();
            v[k] = pad_data;
        end
    endtask

    task automatic read_frame(output logic [7:0] v);
        pulse_latch();
        read_bits(v);
    endtask

    initial begin
        logic [7:0] v;
        reset_n                = 1'b0;
        pad_latch              = 1'b0;
        pad_shift              = 1'b0;
        btn_if.press_activated = '0;

        // reset state
        tick(4);
        check_vec("rst_pad_data", 32'(pad_data), 32'd1);
        check_vec("rst_accepted", 32'(btn_if.press_accepted), 32'h00);
        check_vec("rst_held", 32'(buttons_held), 32'h00);
        reset_n = 1'b1;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            pulse_shift();
            check_vec("rst_shift_data", 32'(pad_data), 32'd1);
        end
        check_vec("rst_no_ack", ack0_cnt, 32'd0);

        // single press on button 0
        btn_if.press_activated = 8'h01;
        tick(1);
        btn_if.press_activated = 8'h00;
        check_vec("single_ack", 32'(btn_if.press_accepted), 32'h01);
        check_vec("single_held_pre", 32'(buttons_held), 32'h00);
        tick(1);
        check_vec("single_ack_drop", 32'(btn_if.press_accepted), 32'h00);
        check_vec("single_held", 32'(buttons_held), 32'h01);
        read_frame(v);
        check_vec("single_frame1", 32'(v), 32'h7F);
        read_frame(v);
        check_vec("single_frame2", 32'(v), 32'h7F);
        check_vec("single_held_clr", 32'(buttons_held), 32'h00);
        read_frame(v);
        check_vec("single_frame3", 32'(v), 32'hFF);
        check_vec("single_ack_count", ack0_cnt, 32'd1);

        // multi-button press
        btn_if.press_activated = 8'h85;
        tick(1);
        btn_if.press_activated = 8'h00;
        check_vec("multi_ack", 32'(btn_if.press_accepted), 32'h85);
        tick(1);
        check_vec("multi_ack_drop", 32'(btn_if.press_accepted), 32'h00);
        check_vec("multi_held", 32'(buttons_held), 32'h85);
        read_frame(v);
        check_vec("multi_frame1", 32'(v), 32'h5E);
        read_frame(v);
        check_vec("multi_frame2", 32'(v), 32'h5E);
        read_frame(v);
        check_vec("multi_frame3", 32'(v), 32'hFF);

        // request held high throughout HOLD is ignored until IDLE
        ack0_cnt = 0;
        btn_if.press_activated = 8'h01;
        tick(1);
        check_vec("ign_ack1", 32'(btn_if.press_accepted), 32'h01);
        tick(1);
        check_vec("ign_held", 32'(buttons_held), 32'h01);
        read_frame(v);
        check_vec("ign_frame1", 32'(v), 32'h7F);
        check_vec("ign_no_reack", ack0_cnt, 32'd1);
        pad_latch = 1'b1;
        tick(1);
        pad_latch = 1'b0;
        tick(SYNC_LAT);
        check_vec("ign_idle_held", 32'(buttons_held), 32'h00);
        check_vec("ign_idle_ack", 32'(btn_if.press_accepted), 32'h00);
        check_vec("ign_last_load", 32'(pad_data), 32'd0);
        tick(1);
        check_vec("ign_ack2", 32'(btn_if.press_accepted), 32'h01);
        btn_if.press_activated = 8'h00;
        tick(1);
        check_vec("ign_ack2_drop", 32'(btn_if.press_accepted), 32'h00);
        check_vec("ign_ack_count", ack0_cnt, 32'd2);
        read_frame(v);
        read_frame(v);
        check_vec("ign_drained", 32'(buttons_held), 32'h00);

        // latch and shift in the same cycle: latch wins
        btn_if.press_activated = 8'h01;
        tick(1);
        btn_if.press_activated = 8'h00;
        tick(1);
        pad_latch = 1'b1;
        pad_shift = 1'b1;
        tick(1);
        pad_latch = 1'b0;
        pad_shift = 1'b0;
        tick(SYNC_LAT);
        check_vec("coll_pad_data", 32'(pad_data), 32'd0);
        tick(1);
        read_bits(v);
        check_vec("coll_load", 32'(v), 32'h7F);
        read_frame(v);
        check_vec("coll_frame2", 32'(v), 32'h7F);
        check_vec("coll_held_clr", 32'(buttons_held), 32'h00);

        // latch coincides with ACK->HOLD: loads FF, counter not consumed
        if (SYNC_LAT == 0) begin
            btn_if.press_activated = 8'h01;
            tick(1);
            btn_if.press_activated = 8'h00;
            pad_latch = 1'b1;
            tick(1);
            pad_latch = 1'b0;
        end else begin
            pad_latch = 1'b1;
            tick(1);
            pad_latch = 1'b0;
            btn_if.press_activated = 8'h01;
            tick(1);
            btn_if.press_activated = 8'h00;
            tick(1);
        end
        check_vec("ackhold_pad_data", 32'(pad_data), 32'd1);
        check_vec("ackhold_held", 32'(buttons_held), 32'h01);
        tick(1);
        read_bits(v);
        check_vec("ackhold_load", 32'(v), 32'hFF);
        read_frame(v);
        check_vec("ackhold_frame1", 32'(v), 32'h7F);
        read_frame(v);
        check_vec("ackhold_frame2", 32'(v), 32'h7F);
        read_frame(v);
        check_vec("ackhold_frame3", 32'(v), 32'hFF);

        // reset while button 3 is held
        btn_if.press_activated = 8'h08;
        tick(1);
        btn_if.press_activated = 8'h00;
        tick(1);
        check_vec("rsth_held", 32'(buttons_held), 32'h08);
        read_frame(v);
        check_vec("rsth_frame1", 32'(v), 32'hEF);
        reset_n = 1'b0;
        tick(1);
        check_vec("rsth_held_clr", 32'(buttons_held), 32'h00);
        check_vec("rsth_pad_data", 32'(pad_data), 32'd1);
        reset_n = 1'b1;
        tick(1);
        read_frame(v);
        check_vec("rsth_frame2", 32'(v), 32'hFF);
        check_vec("rsth_held_after", 32'(buttons_held), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
